// File: rtl/led_pkg.sv
// Shared types and constants for the LED scan display path.
//   scan_state_t : scan FSM encoding (IDLE / DRIVE / GUARD)
//   SEG_BLANK    : all segments off (active-low)
//   SEG_TABLE    : hex nibble -> active-low {g,f,e,d,c,b,a}, index = nibble
package led_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    GUARD
  } scan_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Leftmost entry is nibble F, rightmost is nibble 0.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/led_scan_controller_if.sv
// Display-update handshake between the floor/direction logic (master) and
// the scan controller (slave).
//   digit_data : hex nibble per digit, digit i = bits [4i+3:4i]
//   digit_en   : 1 = digit lit
//   blink_mask : 1 = digit blanked during blink phase 1
//   dp_mask    : 1 = decimal point lit
//   update_req : level, held with data stable until update_ack
//   update_ack : one-cycle pulse, shadow captured on that edge
interface led_scan_controller_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] digit_data;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic                    update_req;
  logic                    update_ack;

  modport master (
    output digit_data, digit_en, blink_mask, dp_mask, update_req,
    input  update_ack
  );

  modport slave (
    input  digit_data, digit_en, blink_mask, dp_mask, update_req,
    output update_ack
  );
endinterface

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low 7-segment decoder.
//   nibble : 4-bit value 0..F
//   seg    : active-low {g,f,e,d,c,b,a}
module hex_to_7seg
  import led_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_TABLE[nibble];
  end

endmodule

// File: rtl/led_scan_controller.sv
// Time-multiplexed scan controller for common-anode 7-segment digits.
// Steps one digit per led_clk rising edge, with GUARD_CYCLES of all-anodes-off
// between digits; display contents come from a shadow register that is only
// reloaded at frame boundaries (or on leaving IDLE) via the update handshake.
//   clk        : system clock
//   reset      : asynchronous active-low reset
//   led_clk    : scan-rate reference, asynchronous level
//   upd        : update handshake/data (slave side)
//   an         : active-low anodes, one-hot-low or all 1
//   seg        : active-low segments {g,f,e,d,c,b,a}
//   dp         : active-low decimal point
//   frame_done : one-cycle pulse when the digit index wraps to 0
module led_scan_controller
  import led_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned GUARD_CYCLES = 2,
  parameter int unsigned BLINK_FRAMES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  led_clk,
  led_scan_controller_if.slave  upd,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_done
);

  localparam int unsigned IDX_W = (NUM_DIGITS > 1)   ? $clog2(NUM_DIGITS)   : 1;
  localparam int unsigned GRD_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam int unsigned BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [GRD_W-1:0] GRD_LOAD = GRD_W'(GUARD_CYCLES - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

  // led_clk synchroniser and rising-edge detect
  logic sync1, sync2, hist, tick;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= led_clk;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  always_comb begin
    tick = sync2 & ~hist;
  end

  // FSM, counters and shadow registers
  scan_state_t             state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [GRD_W-1:0]        grd_q, grd_d;
  logic [BLK_W-1:0]        blk_q, blk_d;
  logic                    phase_q, phase_d;
  logic [4*NUM_DIGITS-1:0] sh_data_q, sh_data_d;
  logic [NUM_DIGITS-1:0]   sh_en_q, sh_en_d;
  logic [NUM_DIGITS-1:0]   sh_blink_q, sh_blink_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic                    wrap, load;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      grd_q      <= '0;
      blk_q      <= '0;
      phase_q    <= 1'b0;
      sh_data_q  <= '0;
      sh_en_q    <= '0;
      sh_blink_q <= '0;
      sh_dp_q    <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      grd_q      <= grd_d;
      blk_q      <= blk_d;
      phase_q    <= phase_d;
      sh_data_q  <= sh_data_d;
      sh_en_q    <= sh_en_d;
      sh_blink_q <= sh_blink_d;
      sh_dp_q    <= sh_dp_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    grd_d      = grd_q;
    blk_d      = blk_q;
    phase_d    = phase_q;
    sh_data_d  = sh_data_q;
    sh_en_d    = sh_en_q;
    sh_blink_d = sh_blink_q;
    sh_dp_d    = sh_dp_q;
    wrap       = 1'b0;
    load       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = DRIVE;
          idx_d   = '0;
          load    = upd.update_req;
        end
      end
      DRIVE: begin
        if (tick) begin
          state_d = GUARD;
          grd_d   = GRD_LOAD;
        end
      end
      GUARD: begin
        // Ticks are deliberately not looked at here: a tick landing in the
        // guard window is dropped rather than queued.
        if (grd_q == '0) begin
          state_d = DRIVE;
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            wrap  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          grd_d = grd_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (wrap) begin
      load = upd.update_req;
      if (blk_q == BLK_LAST) begin
        blk_d   = '0;
        phase_d = ~phase_q;
      end else begin
        blk_d = blk_q + 1'b1;
      end
    end

    if (load) begin
      sh_data_d  = upd.digit_data;
      sh_en_d    = upd.digit_en;
      sh_blink_d = upd.blink_mask;
      sh_dp_d    = upd.dp_mask;
    end
  end

  // Output decode works on the *next* state/shadow so the registered outputs
  // line up with the state entered on the same edge.
  logic [3:0]            nibble;
  logic [6:0]            seg_hex;
  logic                  lit;
  logic [NUM_DIGITS-1:0] an_d;
  logic [6:0]            seg_d;
  logic                  dp_d;

  always_comb begin
    nibble = sh_data_d[idx_d*4 +: 4];
  end

  hex_to_7seg u_hex (
    .nibble (nibble),
    .seg    (seg_hex)
  );

  always_comb begin
    lit   = (state_d == DRIVE) && sh_en_d[idx_d] && !(sh_blink_d[idx_d] && phase_d);
    an_d  = '1;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (lit) begin
      an_d[idx_d] = 1'b0;
      seg_d       = seg_hex;
      dp_d        = ~sh_dp_d[idx_d];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an             <= '1;
      seg            <= SEG_BLANK;
      dp             <= 1'b1;
      frame_done     <= 1'b0;
      upd.update_ack <= 1'b0;
    end else begin
      an             <= an_d;
      seg            <= seg_d;
      dp             <= dp_d;
      frame_done     <= wrap;
      upd.update_ack <= load;
    end
  end

endmodule

// File: tb/tb_led_scan_controller.sv
// Scoreboard bench for led_scan_controller: each lit digit slot the bench
// expects is queued when the stimulus that causes it is driven, and compared
// when the slot ends on the anode outputs.
module tb_led_scan_controller;

  localparam int unsigned ND = 4;
  localparam int unsigned GC = 2;
  localparam int unsigned BF = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       led_clk = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_done;

  led_scan_controller_if #(.NUM_DIGITS(ND)) upd ();

  led_scan_controller #(
    .NUM_DIGITS   (ND),
    .GUARD_CYCLES (GC),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .led_clk    (led_clk),
    .upd        (upd),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // led_clk period = 16 clk cycles, offset from the clk edges
  initial begin
    #3;
    forever #80 led_clk = ~led_clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] ref_seg(input logic [3:0] n);
    case (n)
      4'h0: ref_seg = 7'h40;  4'h1: ref_seg = 7'h79;
      4'h2: ref_seg = 7'h24;  4'h3: ref_seg = 7'h30;
      4'h4: ref_seg = 7'h19;  4'h5: ref_seg = 7'h12;
      4'h6: ref_seg = 7'h02;  4'h7: ref_seg = 7'h78;
      4'h8: ref_seg = 7'h00;  4'h9: ref_seg = 7'h10;
      4'hA: ref_seg = 7'h08;  4'hB: ref_seg = 7'h03;
      4'hC: ref_seg = 7'h46;  4'hD: ref_seg = 7'h21;
      4'hE: ref_seg = 7'h06;  default: ref_seg = 7'h0E;
    endcase
  endfunction

  // Bench model of the displayed shadow and blink state
  logic [15:0] m_data;
  logic [3:0]  m_en, m_blink, m_dp;
  int          m_bcnt;
  bit          m_phase;
  logic [11:0] sb[$];

  task automatic push_frame();
    logic [3:0] an_e;
    for (int i = 0; i < ND; i++) begin
      if (m_en[i] && !(m_blink[i] && m_phase)) begin
        an_e    = 4'hF;
        an_e[i] = 1'b0;
        sb.push_back({an_e, ref_seg(m_data[4*i +: 4]), ~m_dp[i]});
      end
    end
  endtask

  task automatic model_wrap();
    if (m_bcnt == BF - 1) begin
      m_bcnt  = 0;
      m_phase = ~m_phase;
    end else begin
      m_bcnt++;
    end
  endtask

  // Slot monitor
  bit          mon_en = 1'b0;
  bit          gap_chk = 1'b0;
  bit          in_slot = 1'b0;
  bit          prev_valid = 1'b0;
  int          gap = 0;
  logic [11:0] slot_val, cur;

  task automatic close_slot();
    if (sb.size() == 0) check("slot_unexpected", slot_val, 12'hFFF);
    else                check("slot", slot_val, sb.pop_front());
    in_slot    = 1'b0;
    prev_valid = 1'b1;
    gap        = 0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      cur = {an, seg, dp};
      if (an != 4'hF) begin
        if (in_slot && cur != slot_val) close_slot();
        if (!in_slot) begin
          if (gap_chk && prev_valid) check("guard_gap", gap, GC);
          in_slot  = 1'b1;
          slot_val = cur;
        end
      end else begin
        if (in_slot) close_slot();
        gap++;
      end
    end
  end

  task automatic set_inputs(input logic [15:0] d, input logic [3:0] e, b, p);
    upd.digit_data = d;
    upd.digit_en   = e;
    upd.blink_mask = b;
    upd.dp_mask    = p;
  endtask

  // Called just after a frame starts; sets up the next frame and waits for it.
  task automatic run_frame(input bit req, input bit drop_early, input logic [15:0] d,
                           input logic [3:0] e, b, p, input int exp_len);
    int cyc;
    bit ack_early;
    repeat (20) @(negedge clk);
    cyc = 20;
    set_inputs(d, e, b, p);
    upd.update_req = req;
    model_wrap();
    if (req && !drop_early) begin
      m_data = d; m_en = e; m_blink = b; m_dp = p;
    end
    push_frame();
    if (drop_early) begin
      repeat (10) @(negedge clk);
      cyc += 10;
      upd.update_req = 1'b0;
    end
    ack_early = 1'b0;
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (frame_done) break;
      ack_early |= upd.update_ack;
    end
    check("frame_len", cyc, exp_len);
    check("ack_at_wrap", upd.update_ack, req && !drop_early);
    check("ack_early", ack_early, 1'b0);
    upd.update_req = 1'b0;
  endtask

  // Waits for the IDLE exit after reset release; ack must land on the 3rd
  // clk edge after led_clk rises (2 negedge samples after it is first seen).
  task automatic wait_first_ack();
    int  cnt;
    int  rise_n;
    bit  fd_seen;
    cnt     = 0;
    rise_n  = -1000;
    fd_seen = 1'b0;
    while (cnt < 100) begin
      @(negedge clk);
      cnt++;
      if (led_clk && rise_n < 0) rise_n = cnt;
      if (upd.update_ack) break;
      fd_seen |= frame_done;
    end
    check("ack_latency", cnt - rise_n, 2);
    check("ack_frame_done", frame_done, 1'b0);
    check("frame_done_before_ack", fd_seen, 1'b0);
    upd.update_req = 1'b0;
  endtask

  task automatic release_reset_low_phase();
    for (int k = 0; k < 40 && led_clk; k++) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    set_inputs(16'h1234, 4'hF, 4'h0, 4'h0);
    upd.update_req = 1'b0;
    #1 reset = 1'b0;

    repeat (30) @(negedge clk);
    check("rst_an", an, 4'hF);
    check("rst_seg", seg, 7'h7F);
    check("rst_dp", dp, 1'b1);
    check("rst_ack", upd.update_ack, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);

    m_data = 16'h1234; m_en = 4'hF; m_blink = 4'h0; m_dp = 4'h0;
    m_bcnt = 0; m_phase = 1'b0;
    upd.update_req = 1'b1;
    push_frame();
    gap_chk = 1'b1;
    mon_en  = 1'b1;
    release_reset_low_phase();
    wait_first_ack();

    run_frame(1'b0, 1'b0, 16'h5555, 4'hF, 4'h0, 4'h0, 66);
    run_frame(1'b1, 1'b0, 16'hABCD, 4'hF, 4'h0, 4'b0010, 64);
    run_frame(1'b1, 1'b1, 16'h0000, 4'h0, 4'h0, 4'h0, 64);
    gap_chk = 1'b0;
    run_frame(1'b1, 1'b0, 16'h0F87, 4'b0101, 4'h0, 4'b0101, 64);
    run_frame(1'b0, 1'b0, 16'h0F87, 4'b0101, 4'h0, 4'b0101, 64);
    run_frame(1'b1, 1'b0, 16'h9E60, 4'hF, 4'b0001, 4'h0, 64);
    repeat (4) run_frame(1'b0, 1'b0, 16'h9E60, 4'hF, 4'b0001, 4'h0, 64);

    // Reset while digit 2 is being driven, in blink phase 1
    for (int k = 0; k < 70 && an != 4'b1011; k++) @(negedge clk);
    check("digit2_driven", an, 4'b1011);
    mon_en = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("async_rst_an", an, 4'hF);
    check("async_rst_seg", seg, 7'h7F);
    check("async_rst_dp", dp, 1'b1);
    sb.delete();
    in_slot    = 1'b0;
    prev_valid = 1'b0;
    gap        = 0;
    repeat (20) @(negedge clk);
    check("hold_rst_an", an, 4'hF);
    check("hold_rst_ack", upd.update_ack, 1'b0);

    // Blink phase must restart at 0: digit 0 visible in the first two frames
    m_data = 16'h8421; m_en = 4'hF; m_blink = 4'b0001; m_dp = 4'b1000;
    m_bcnt = 0; m_phase = 1'b0;
    set_inputs(m_data, m_en, m_blink, m_dp);
    upd.update_req = 1'b1;
    push_frame();
    mon_en = 1'b1;
    release_reset_low_phase();
    wait_first_ack();
    run_frame(1'b0, 1'b0, 16'h8421, 4'hF, 4'b0001, 4'b1000, 66);

    repeat (70) @(negedge clk);
    mon_en = 1'b0;
    check("sb_left", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
